debug_bus_ram: RTL

- Word-addressed RAM slave that consumes the debug UART bridge's read/write master interface (wreq/wgnt, rreq/rgnt).
- Adds programmable wait states and an address window.
- Out-of-window accesses are never granted, so the master hits its timeout path; a sticky error flag records the event.
- Read data follows the bridge's default capture mode: rdata is valid in the cycle after rgnt.

---
 rtl/debug_bus_ram_if.sv | 25 ++
 rtl/debug_bus_ram.sv | 100 ++++++++++
 2 files changed

// File: rtl/debug_bus_ram_if.sv
// Read/write master-slave bus between the debug UART bridge and a RAM slave.
// Requests are held by the master; grants are single-cycle pulses from the slave.
interface debug_bus_ram_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          wreq;
    logic          wgnt;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          rreq;
    logic          rgnt;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;

    modport master (
        output wreq, waddr, wdata, rreq, raddr,
        input  wgnt, rgnt, rdata
    );

    modport slave (
        input  wreq, waddr, wdata, rreq, raddr,
        output wgnt, rgnt, rdata
    );
endinterface

// File: rtl/debug_bus_ram.sv
// Word-addressed RAM slave for the debug bridge with programmable wait states and
// an address window; out-of-window requests are never granted and set a sticky err.
module debug_bus_ram #(
    parameter int                           ADDR_BYTE_WIDTH = 4,
    parameter int                           DATA_BYTE_WIDTH = 4,
    parameter int                           DEPTH_LOG2      = 8,
    parameter logic [8*ADDR_BYTE_WIDTH-1:0] BASE_ADDR       = '0,
    parameter int                           WAIT_CYCLES     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    debug_bus_ram_if.slave        bus,
    output logic                  err
);
    localparam int AW    = 8 * ADDR_BYTE_WIDTH;
    localparam int DW    = 8 * DATA_BYTE_WIDTH;
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [AW:0] DEPTH_EXT = (AW+1)'(1) << DEPTH_LOG2;
    localparam logic [7:0]  WAIT_INIT = 8'(WAIT_CYCLES);

    typedef enum logic [2:0] {IDLE, WAIT_W, WAIT_R, GNT_W, GNT_R} state_t;

    state_t                state, state_d;
    logic [7:0]            cnt, cnt_d;
    logic [DEPTH_LOG2-1:0] idx, idx_d;
    logic                  err_set;
    logic [DW-1:0]         mem [DEPTH];

    // Offset computed in AW+1 bits: the top bit is the borrow, i.e. addr < BASE_ADDR.
    logic [AW:0] w_off, r_off;
    logic        w_hit, r_hit;

    always_comb begin
        w_off = {1'b0, bus.waddr} - {1'b0, BASE_ADDR};
        r_off = {1'b0, bus.raddr} - {1'b0, BASE_ADDR};
        w_hit = !w_off[AW] && (w_off < DEPTH_EXT);
        r_hit = !r_off[AW] && (r_off < DEPTH_EXT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
            if (err_set) err <= 1'b1;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        err_set = 1'b0;
        case (state)
            IDLE: begin
                err_set = (bus.wreq && !w_hit) || (bus.rreq && !r_hit);
                if (bus.wreq && w_hit) begin
                    idx_d   = w_off[DEPTH_LOG2-1:0];
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES == 0) ? GNT_W : WAIT_W;
                end else if (bus.rreq && r_hit) begin
                    idx_d   = r_off[DEPTH_LOG2-1:0];
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES == 0) ? GNT_R : WAIT_R;
                end
            end
            WAIT_W: begin
                if (!bus.wreq)        state_d = IDLE;
                else if (cnt == 8'd1) state_d = GNT_W;
                else                  cnt_d   = cnt - 8'd1;
            end
            WAIT_R: begin
                if (!bus.rreq)        state_d = IDLE;
                else if (cnt == 8'd1) state_d = GNT_R;
                else                  cnt_d   = cnt - 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.wgnt = (state == GNT_W) && bus.wreq;
        bus.rgnt = (state == GNT_R) && bus.rreq;
    end

    // RAM array kept out of the reset block; a reset cycle suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && bus.wgnt) mem[idx] <= bus.wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)           bus.rdata <= '0;
        else if (bus.rgnt) bus.rdata <= mem[idx];
    end
endmodule
